// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: parametrised request encoder with fixed or round-robin
// priority. The winner is computed combinationally from the request vector
// and a priority pointer. The result is delivered through a one-entry
// valid/ready output register.
module prio_encoder_rr #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 3,
  parameter bit RR_MODE      = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [INPUT_WIDTH-1:0]  dec_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] bin_out,
  output logic [INPUT_WIDTH-1:0]  grant_out,
  output logic                    none_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam logic [OUTPUT_WIDTH-1:0] TOP_IDX = OUTPUT_WIDTH'(INPUT_WIDTH - 1);

  // Search start position. The highest priority goes to this bit, and
  // priority descends from it. It only ever holds values below INPUT_WIDTH.
  logic [OUTPUT_WIDTH-1:0] ptr;

  logic                    accept;
  logic                    found;
  logic [OUTPUT_WIDTH-1:0] win_idx;
  logic [INPUT_WIDTH-1:0]  win_grant;
  logic [OUTPUT_WIDTH-1:0] ptr_next;

  // The output slot is free when it is empty, or when it is being drained in
  // this same cycle. That gives one result per cycle when there is no stall.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept   = in_valid && in_ready;
  end

  // Circular search split into two linear passes. The first pass finds the
  // highest set bit at or below ptr. If that fails, the second pass finds the
  // highest set bit above ptr, which is the wrapped part of the circular order.
  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    win_grant = '0;
    for (int j = INPUT_WIDTH - 1; j >= 0; j--) begin
      if (!found && dec_in[j] && (j <= int'(ptr))) begin
        found        = 1'b1;
        win_idx      = OUTPUT_WIDTH'(j);
        win_grant    = '0;
        win_grant[j] = 1'b1;
      end
    end
    for (int j = INPUT_WIDTH - 1; j >= 0; j--) begin
      if (!found && dec_in[j] && (j > int'(ptr))) begin
        found        = 1'b1;
        win_idx      = OUTPUT_WIDTH'(j);
        win_grant    = '0;
        win_grant[j] = 1'b1;
      end
    end
  end

  // The bit just served moves to the lowest priority. Bit 0 wraps to the
  // real top bit, not to the top of the index encoding.
  always_comb begin
    ptr_next = ptr;
    if (found) begin
      if (win_idx == '0) begin
        ptr_next = TOP_IDX;
      end else begin
        ptr_next = win_idx - OUTPUT_WIDTH'(1);
      end
    end
  end

  // Pointer register. It only advances on an accepted non-zero request in
  // round-robin mode. In fixed mode it never leaves the top bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= TOP_IDX;
    end else if (RR_MODE && accept && found) begin
      ptr <= ptr_next;
    end
  end

  // One-entry output register. It loads on accept and empties when the
  // consumer takes the result. The data may stay stale while the slot is
  // empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      bin_out   <= '0;
      grant_out <= '0;
      none_out  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bin_out   <= win_idx;
      grant_out <= win_grant;
      none_out  <= !found;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
